// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic initiator bridge:
// response status codes and the bridge FSM state encoding.
package wb_pkg;

  localparam logic [1:0] WB_ST_OK  = 2'b00;
  localparam logic [1:0] WB_ST_ERR = 2'b01;
  localparam logic [1:0] WB_ST_TMO = 2'b10;

  typedef enum logic [1:0] {
    WBM_IDLE = 2'd0,
    WBM_BUS  = 2'd1,
    WBM_RESP = 2'd2
  } wbm_state_t;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Bus-cycle watchdog: clearable, enabled up-counter whose expire flag is high
// while the count sits at TIMEOUT-1.
module wbm_timeout_ctr #(
  parameter int TIMEOUT   = 64,
  parameter int TIMEOUT_W = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator: one command on the valid/ready port becomes one
// single-beat bus cycle, answered by one response carrying data and status.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int TIMEOUT_W = 7
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  wbm_state_t  state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic        ctr_clr, ctr_en, ctr_expire;

  wbm_timeout_ctr #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_tmo (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (ctr_clr),
    .en_i     (ctr_en),
    .expire_o (ctr_expire)
  );

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    busy_d       = busy_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    sel_d        = sel_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    ctr_clr      = 1'b0;
    ctr_en       = 1'b0;
    case (state_q)
      WBM_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          we_d        = cmd_we;
          adr_d       = cmd_adr;
          sel_d       = cmd_sel;
          dat_d       = cmd_we ? cmd_dat : 32'h0;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          ctr_clr     = 1'b1;
          state_d     = WBM_BUS;
        end
      end
      WBM_BUS: begin
        ctr_en = 1'b1;
        // err beats ack, and either beats a timeout expiring in the same cycle
        if (wbm_err_i || wbm_ack_i || ctr_expire) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = 32'h0;
          state_d     = WBM_RESP;
          if (wbm_err_i) begin
            rsp_status_d = WB_ST_ERR;
          end else if (wbm_ack_i) begin
            rsp_status_d = WB_ST_OK;
            rsp_dat_d    = we_q ? 32'h0 : wbm_dat_i;
          end else begin
            rsp_status_d = WB_ST_TMO;
          end
        end
      end
      WBM_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = WBM_IDLE;
        end
      end
      default: begin
        state_d     = WBM_IDLE;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= WBM_IDLE;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= WB_ST_OK;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_we_o   = we_q;
  assign wbm_sel_o  = sel_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: the bench plays command source, response
// sink and Wishbone slave, driving on falling edges and checking there too.
module tb_wb_master_bridge;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        busy;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  int errors = 0;
  int checks = 0;
  int cyc_cnt;

  wb_master_bridge #(.TIMEOUT(64), .TIMEOUT_W(7)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .cmd_sel    (cmd_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_status (rsp_status),
    .busy       (busy),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_err_i  (wbm_err_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no end of test, expected $finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one command for a single IDLE cycle, then scrambles the command
  // port; returns on the falling edge of the first BUS cycle.
  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we    = ~we;
    cmd_adr   = ~adr;
    cmd_dat   = ~dat;
    cmd_sel   = ~sel;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_cyc",       {31'b0, wbm_cyc_o}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);

    // Write, ack on the second BUS cycle
    send(1'b1, 32'h3200_0004, 32'hA5A5_0001, 4'hF);
    chk("t1_cyc",       {31'b0, wbm_cyc_o}, 32'd1);
    chk("t1_stb",       {31'b0, wbm_stb_o}, 32'd1);
    chk("t1_we",        {31'b0, wbm_we_o},  32'd1);
    chk("t1_adr",       wbm_adr_o,          32'h3200_0004);
    chk("t1_dat",       wbm_dat_o,          32'hA5A5_0001);
    chk("t1_sel",       {28'b0, wbm_sel_o}, 32'hF);
    chk("t1_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("t1_busy",      {31'b0, busy},      32'd1);
    @(negedge clk);
    chk("t1_cyc_c1",    {31'b0, wbm_cyc_o}, 32'd1);
    chk("t1_adr_hold",  wbm_adr_o,          32'h3200_0004);
    chk("t1_dat_hold",  wbm_dat_o,          32'hA5A5_0001);
    wbm_ack_i = 1'b1;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    chk("t1_cyc_drop",  {31'b0, wbm_cyc_o}, 32'd0);
    chk("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t1_status",    {30'b0, rsp_status}, 32'd0);
    chk("t1_rsp_dat",   rsp_dat,            32'h0);
    take_rsp();
    chk("t1_rsp_done",  {31'b0, rsp_valid}, 32'd0);
    chk("t1_ready_back",{31'b0, cmd_ready}, 32'd1);

    // Read, slave acks in the first BUS cycle
    send(1'b0, 32'h3200_0008, 32'hDEAD_BEEF, 4'hF);
    chk("t2_we",        {31'b0, wbm_we_o},  32'd0);
    chk("t2_dat_o",     wbm_dat_o,          32'h0);
    chk("t2_rsp_early", {31'b0, rsp_valid}, 32'd0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h1234_5678;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'hFFFF_FFFF;
    chk("t2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t2_rsp_dat",   rsp_dat,            32'h1234_5678);
    chk("t2_status",    {30'b0, rsp_status}, 32'd0);
    @(negedge clk);
    chk("t2_rsp_hold",  rsp_dat,            32'h1234_5678);
    take_rsp();

    // Stray ack while idle must not complete the next transaction
    wbm_ack_i = 1'b1;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    chk("stray_rsp",    {31'b0, rsp_valid}, 32'd0);

    // Read, err on the third BUS cycle
    send(1'b0, 32'h3200_000C, 32'h0, 4'hF);
    @(negedge clk);
    chk("t3_cyc_c1",    {31'b0, wbm_cyc_o}, 32'd1);
    @(negedge clk);
    chk("t3_cyc_c2",    {31'b0, wbm_cyc_o}, 32'd1);
    wbm_err_i = 1'b1;
    wbm_dat_i = 32'h55AA_55AA;
    @(negedge clk);
    wbm_err_i = 1'b0;
    chk("t3_cyc_drop",  {31'b0, wbm_cyc_o}, 32'd0);
    chk("t3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t3_status",    {30'b0, rsp_status}, 32'd1);
    chk("t3_rsp_dat",   rsp_dat,            32'h0);
    take_rsp();

    // ack and err together count as an error
    send(1'b0, 32'h3200_000C, 32'h0, 4'hF);
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    wbm_dat_i = 32'h1111_1111;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    chk("t3b_status",   {30'b0, rsp_status}, 32'd1);
    chk("t3b_rsp_dat",  rsp_dat,            32'h0);
    take_rsp();

    // No slave response: cyc high for exactly TIMEOUT cycles
    send(1'b0, 32'h3200_0010, 32'h0, 4'hF);
    cyc_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (wbm_cyc_o) cyc_cnt++;
      else break;
      @(negedge clk);
    end
    chk("t4_cyc_cycles", cyc_cnt,           32'd64);
    chk("t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t4_status",    {30'b0, rsp_status}, 32'd2);
    chk("t4_rsp_dat",   rsp_dat,            32'h0);
    take_rsp();

    // ack arriving on the cycle the timeout would fire wins
    send(1'b0, 32'h3200_0010, 32'h0, 4'hF);
    repeat (63) @(negedge clk);
    chk("t4b_cyc_last", {31'b0, wbm_cyc_o}, 32'd1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    chk("t4b_status",   {30'b0, rsp_status}, 32'd0);
    chk("t4b_rsp_dat",  rsp_dat,            32'hCAFE_F00D);
    take_rsp();

    // Back-pressure on the response with a second command waiting
    send(1'b1, 32'h3200_0014, 32'h0BAD_F00D, 4'h3);
    chk("t5_sel",       {28'b0, wbm_sel_o}, 32'h3);
    wbm_ack_i = 1'b1;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3200_0018;
    cmd_sel   = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("t5_rsp_held",  {31'b0, rsp_valid}, 32'd1);
      chk("t5_ready_low", {31'b0, cmd_ready}, 32'd0);
      chk("t5_no_cyc",    {31'b0, wbm_cyc_o}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_rsp_taken", {31'b0, rsp_valid}, 32'd0);
    chk("t5_ready_up",  {31'b0, cmd_ready}, 32'd1);
    chk("t5_not_yet",   {31'b0, wbm_cyc_o}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t5_cmd2_cyc",  {31'b0, wbm_cyc_o}, 32'd1);
    chk("t5_cmd2_adr",  wbm_adr_o,          32'h3200_0018);
    chk("t5_cmd2_we",   {31'b0, wbm_we_o},  32'd0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h7777_0001;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    chk("t5_cmd2_rsp",  {31'b0, rsp_valid}, 32'd1);
    chk("t5_cmd2_dat",  rsp_dat,            32'h7777_0001);
    @(negedge clk);
    chk("t5_no_dup1",   {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("t5_no_dup2",   {31'b0, rsp_valid}, 32'd0);
    chk("t5_idle",      {31'b0, cmd_ready}, 32'd1);
    rsp_ready = 1'b0;

    // Asynchronous reset in the middle of a bus cycle
    send(1'b1, 32'h3200_0020, 32'h0000_00FF, 4'hF);
    chk("t6_cyc_pre",   {31'b0, wbm_cyc_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_cyc_async", {31'b0, wbm_cyc_o}, 32'd0);
    chk("t6_stb_async", {31'b0, wbm_stb_o}, 32'd0);
    chk("t6_ready",     {31'b0, cmd_ready}, 32'd1);
    chk("t6_busy",      {31'b0, busy},      32'd0);
    chk("t6_adr_zero",  wbm_adr_o,          32'h0);
    @(negedge clk);
    rst = 1'b0;
    wbm_ack_i = 1'b1;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    chk("t6_no_rsp1",   {31'b0, rsp_valid}, 32'd0);
    chk("t6_no_cyc",    {31'b0, wbm_cyc_o}, 32'd0);
    @(negedge clk);
    chk("t6_no_rsp2",   {31'b0, rsp_valid}, 32'd0);
    chk("t6_ready2",    {31'b0, cmd_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
